// File: rtl/i2c_sniffer_pkg.sv
// rtl/i2c_sniffer_pkg.sv - shared record types and constants for the multi-bus I2C sniffer
package i2c_sniffer_pkg;

    localparam int KIND_W = 2;
    localparam int BYTE_W = 8;
    localparam int REC_W  = KIND_W + BYTE_W + 1;

    typedef enum logic [KIND_W-1:0] {
        KIND_START  = 2'd0,
        KIND_RSTART = 2'd1,
        KIND_STOP   = 2'd2,
        KIND_BYTE   = 2'd3
    } rec_kind_e;

    typedef struct packed {
        rec_kind_e         kind;
        logic [BYTE_W-1:0] data;
        logic              ack;
    } sniff_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BITS   = 2'd1,
        ST_ACKBIT = 2'd2
    } sniff_state_e;

endpackage

// File: rtl/i2c_bus_sniffer.sv
// rtl/i2c_bus_sniffer.sv - one-bus observer: synchroniser, glitch filter, frame FSM, pending slot
module i2c_bus_sniffer
    import i2c_sniffer_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       enable_i,
    input  logic       grant_i,
    input  logic       ovf_clr_i,
    output logic       slot_valid_o,
    output sniff_rec_t slot_rec_o,
    output logic       busy_o,
    output logic       ovf_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
    logic [1:0]            raw, sync1, sync2, filt, filt_q;
    logic [1:0][CNT_W-1:0] stab_cnt;

    assign raw = {scl_i, sda_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            filt_q   <= 2'b11;
            stab_cnt <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                    filt[i]     <= sync2[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic scl_f, sda_f, start_ev, stop_ev, rise_ev;

    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign start_ev = scl_f && filt_q[1] && filt_q[0] && !sda_f;
    assign stop_ev  = scl_f && filt_q[1] && !filt_q[0] && sda_f;
    assign rise_ev  = scl_f && !filt_q[1];

    sniff_state_e      state, state_nxt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              ev_valid;
    sniff_rec_t        ev_rec;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable_i) begin
            state_nxt = ST_IDLE;
        end else if (start_ev) begin
            state_nxt = ST_BITS;
        end else if (stop_ev) begin
            state_nxt = ST_IDLE;
        end else if (rise_ev) begin
            case (state)
                ST_BITS:   if (bit_cnt == 3'd7) state_nxt = ST_ACKBIT;
                ST_ACKBIT: state_nxt = ST_BITS;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ev_valid = 1'b0;
        ev_rec   = '0;
        if (enable_i) begin
            if (start_ev) begin
                ev_valid    = 1'b1;
                ev_rec.kind = (state == ST_IDLE) ? KIND_START : KIND_RSTART;
            end else if (stop_ev && state != ST_IDLE) begin
                ev_valid    = 1'b1;
                ev_rec.kind = KIND_STOP;
            end else if (rise_ev && state == ST_ACKBIT) begin
                ev_valid    = 1'b1;
                ev_rec.kind = KIND_BYTE;
                ev_rec.data = shreg;
                ev_rec.ack  = !sda_f;
            end
        end
    end

    // Bit counter wraps 7 -> 0 on the 8th sample, so the ACK phase needs no reload.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (!enable_i || start_ev) begin
            bit_cnt <= '0;
        end else if (rise_ev && state == ST_BITS) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[BYTE_W-2:0], sda_f};
        end
    end

    assign busy_o = (state != ST_IDLE);

    // A slot being granted this cycle can accept a new record in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_valid_o <= 1'b0;
            slot_rec_o   <= '0;
            ovf_o        <= 1'b0;
        end else begin
            if (ev_valid && (!slot_valid_o || grant_i)) begin
                slot_valid_o <= 1'b1;
                slot_rec_o   <= ev_rec;
            end else if (grant_i) begin
                slot_valid_o <= 1'b0;
            end
            if (ev_valid && slot_valid_o && !grant_i) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_multibus_sniffer.sv
// rtl/i2c_multibus_sniffer.sv - N-bus passive I2C observer merged through a round-robin arbiter and FIFO
module i2c_multibus_sniffer
    import i2c_sniffer_pkg::*;
#(
    parameter int NUM_BUSES  = 16,
    parameter int FILTER_LEN = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_BUSES-1:0]              scl_i,
    input  logic [NUM_BUSES-1:0]              sda_i,
    input  logic [NUM_BUSES-1:0]              enable_i,
    output logic                              rec_valid_o,
    input  logic                              rec_ready_i,
    output logic [$clog2(NUM_BUSES)+10:0]     rec_data_o,
    output logic [NUM_BUSES-1:0]              busy_o,
    output logic [NUM_BUSES-1:0]              ovf_o,
    input  logic                              ovf_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_cnt_o
);

    localparam int ID_W  = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int OUT_W = $clog2(NUM_BUSES) + REC_W;
    localparam int ENT_W = ID_W + REC_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [NUM_BUSES-1:0] slot_valid, grant;
    sniff_rec_t           slot_rec [NUM_BUSES];

    for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
        i2c_bus_sniffer #(.FILTER_LEN(FILTER_LEN)) u_sniffer (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .scl_i        (scl_i[b]),
            .sda_i        (sda_i[b]),
            .enable_i     (enable_i[b]),
            .grant_i      (grant[b]),
            .ovf_clr_i    (ovf_clr_i),
            .slot_valid_o (slot_valid[b]),
            .slot_rec_o   (slot_rec[b]),
            .busy_o       (busy_o[b]),
            .ovf_o        (ovf_o[b])
        );
    end

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic             fifo_full, push, pop, gnt_any;
    logic [ID_W-1:0]  gnt_id, last_id;

    assign fifo_full = (cnt == (AW+1)'(FIFO_DEPTH));

    // Search starts one past the last granted bus so no bus can starve.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = last_id;
        for (int i = 1; i <= NUM_BUSES; i++) begin
            if (!gnt_any && slot_valid[(int'(last_id) + i) % NUM_BUSES]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'((int'(last_id) + i) % NUM_BUSES);
            end
        end
        if (fifo_full) gnt_any = 1'b0;
    end

    always_comb begin
        grant = '0;
        for (int b = 0; b < NUM_BUSES; b++) begin
            grant[b] = gnt_any && (gnt_id == ID_W'(b));
        end
    end

    assign push = gnt_any;
    assign pop  = rec_valid_o && rec_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_id <= ID_W'(NUM_BUSES - 1);
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            if (push) begin
                last_id <= gnt_id;
                wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {gnt_id, slot_rec[gnt_id]};
    end

    assign rec_valid_o = (cnt != '0);
    assign rec_data_o  = rec_valid_o ? mem[rd_ptr][OUT_W-1:0] : '0;
    assign fifo_cnt_o  = cnt;

endmodule

// File: tb/tb_i2c_multibus_sniffer.sv
// tb/tb_i2c_multibus_sniffer.sv - directed and randomized I2C traffic checked against a record-level model
module tb_i2c_multibus_sniffer;

    localparam int N  = 16;
    localparam int FD = 8;
    localparam int HP = 8;
    localparam int RW = 15;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [N-1:0]  scl       = '1;
    logic [N-1:0]  sda       = '1;
    logic [N-1:0]  en        = '1;
    logic          rec_ready = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          rec_valid;
    logic [RW-1:0] rec_data;
    logic [N-1:0]  busy, ovf;
    logic [3:0]    fifo_cnt;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q[$];
    logic [N-1:0]  m_busy;
    logic [N-1:0]  m_ovf;
    int            m_last;
    bit            m_stall;

    always #5 clk = ~clk;

    i2c_multibus_sniffer #(.NUM_BUSES(N), .FILTER_LEN(4), .FIFO_DEPTH(FD)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .scl_i       (scl),
        .sda_i       (sda),
        .enable_i    (en),
        .rec_valid_o (rec_valid),
        .rec_ready_i (rec_ready),
        .rec_data_o  (rec_data),
        .busy_o      (busy),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .fifo_cnt_o  (fifo_cnt)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int b, input int kind, input logic [7:0] d, input logic ack);
        return {4'(b), 2'(kind), d, ack};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy  = '0;
        m_ovf   = '0;
        m_last  = N - 1;
        m_stall = 1'b0;
    endtask

    // ev: 0 = start condition, 1 = stop condition, 2 = completed byte.
    // Simultaneous records leave in round-robin order starting after the last one queued.
    task automatic model_event(input logic [N-1:0] m, input int ev, input logic [7:0] d, input logic ack);
        int            first;
        int            b;
        bit            emit;
        logic [RW-1:0] r;
        first = m_last;
        for (int i = 1; i <= N; i++) begin
            b = (first + i) % N;
            if (m[b] && en[b]) begin
                emit = m_busy[b];
                if (ev == 0) begin
                    r         = mk(b, m_busy[b] ? 1 : 0, 8'h00, 1'b0);
                    emit      = 1'b1;
                    m_busy[b] = 1'b1;
                end else if (ev == 1) begin
                    r         = mk(b, 2, 8'h00, 1'b0);
                    m_busy[b] = 1'b0;
                end else begin
                    r = mk(b, 3, d, ack);
                end
                if (emit) begin
                    if (m_stall && exp_q.size() >= FD + 1) begin
                        m_ovf[b] = 1'b1;
                    end else begin
                        exp_q.push_back(r);
                        m_last = b;
                    end
                end
            end
        end
    endtask

    task automatic drv_bit(input logic [N-1:0] m, input logic v);
        sda = v ? (sda | m) : (sda & ~m);
        wait_cyc(HP);
        scl = scl | m;
        wait_cyc(HP);
        scl = scl & ~m;
        wait_cyc(HP);
    endtask

    task automatic drv_start(input logic [N-1:0] m);
        sda = sda | m;
        wait_cyc(HP);
        scl = scl | m;
        wait_cyc(HP);
        sda = sda & ~m;
        wait_cyc(HP);
        scl = scl & ~m;
        wait_cyc(HP);
        model_event(m, 0, 8'h00, 1'b0);
    endtask

    task automatic drv_stop(input logic [N-1:0] m);
        sda = sda & ~m;
        wait_cyc(HP);
        scl = scl | m;
        wait_cyc(HP);
        sda = sda | m;
        wait_cyc(HP);
        model_event(m, 1, 8'h00, 1'b0);
    endtask

    task automatic drv_byte(input logic [N-1:0] m, input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) drv_bit(m, d[i]);
        drv_bit(m, !ack);
        model_event(m, 2, d, ack);
    endtask

    task automatic pop_expect(input logic [RW-1:0] want, input string tag);
        int n;
        n = 0;
        while (rec_valid !== 1'b1 && n < 300) begin
            wait_cyc(1);
            n++;
        end
        check(tag, 32'({rec_valid, rec_data}), 32'({1'b1, want}));
        rec_ready = 1'b1;
        wait_cyc(1);
        rec_ready = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        while (exp_q.size() > 0) pop_expect(exp_q.pop_front(), tag);
        wait_cyc(4);
        check({tag, "_empty"}, 32'({rec_valid, fifo_cnt}), 32'(0));
    endtask

    function automatic logic [N-1:0] bus_mask(input int b);
        logic [N-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [N-1:0] m;
        int           b;
        int           nb;

        model_reset();
        wait_cyc(3);
        check("rst_valid", 32'(rec_valid), 32'(0));
        check("rst_data", 32'(rec_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_cnt", 32'(fifo_cnt), 32'(0));
        rst_n = 1'b1;
        wait_cyc(4);

        // Bus 0: address write followed by one data byte
        m = bus_mask(0);
        drv_start(m);
        check("bus0_busy_on", 32'(busy[0]), 32'(1));
        drv_byte(m, 8'hA0, 1'b1);
        drv_byte(m, 8'h5A, 1'b1);
        drv_stop(m);
        check("bus0_busy_off", 32'(busy[0]), 32'(0));
        drain_all("bus0");

        // Buses 1, 2, 5 change together
        m = bus_mask(1) | bus_mask(2) | bus_mask(5);
        drv_start(m);
        drain_all("coll_start");
        drv_stop(m);
        drain_all("coll_stop");

        // Bus 3: NACKed read address, repeated start, data byte
        m = bus_mask(3);
        drv_start(m);
        drv_byte(m, 8'hA1, 1'b0);
        drv_start(m);
        drv_byte(m, 8'h3C, 1'b1);
        drv_stop(m);
        drain_all("bus3");

        // Short SDA glitch with SCL high is filtered away
        sda[4] = 1'b0;
        wait_cyc(2);
        sda[4] = 1'b1;
        wait_cyc(20);
        check("glitch_cnt", 32'(fifo_cnt), 32'(0));
        check("glitch_busy", 32'(busy), 32'(0));

        // Partial byte then STOP
        m = bus_mask(6);
        drv_start(m);
        for (int i = 0; i < 4; i++) drv_bit(m, 1'($urandom_range(0, 1)));
        drv_stop(m);
        drain_all("partial");

        // Disable mid-byte, re-enable mid-frame
        m = bus_mask(0);
        drv_start(m);
        drain_all("dis_start");
        for (int i = 0; i < 3; i++) drv_bit(m, 1'($urandom_range(0, 1)));
        en[0]     = 1'b0;
        m_busy[0] = 1'b0;
        wait_cyc(2);
        check("dis_busy", 32'(busy[0]), 32'(0));
        for (int i = 0; i < 3; i++) drv_bit(m, 1'($urandom_range(0, 1)));
        en[0] = 1'b1;
        for (int i = 0; i < 3; i++) drv_bit(m, 1'($urandom_range(0, 1)));
        drv_stop(m);
        check("reen_busy", 32'(busy[0]), 32'(0));
        drain_all("disable");

        // Consumer stalled: FIFO fills, slot holds one, next is dropped
        m_stall = 1'b1;
        m = bus_mask(0);
        drv_start(m);
        for (int i = 0; i < 9; i++) drv_byte(m, 8'($urandom), 1'($urandom_range(0, 1)));
        wait_cyc(4);
        check("ovf_cnt", 32'(fifo_cnt), 32'(FD));
        check("ovf_set", 32'(ovf), 32'(m_ovf));
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        m_ovf   = '0;
        wait_cyc(1);
        check("ovf_clr", 32'(ovf), 32'(m_ovf));
        m_stall = 1'b0;
        drain_all("ovf_drain");
        drv_stop(m);
        drain_all("ovf_stop");

        // Random single-bus transactions
        for (int t = 0; t < 4; t++) begin
            b  = $urandom_range(0, N - 1);
            m  = bus_mask(b);
            nb = $urandom_range(1, 3);
            drv_start(m);
            for (int i = 0; i < nb; i++) drv_byte(m, 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                drv_start(m);
                drv_byte(m, 8'($urandom), 1'($urandom_range(0, 1)));
            end
            drv_stop(m);
            drain_all("rand");
        end

        // Reset with records queued
        m = bus_mask(2);
        drv_start(m);
        for (int i = 0; i < 3; i++) drv_byte(m, 8'($urandom), 1'b1);
        drv_stop(m);
        wait_cyc(4);
        check("pre_rst_cnt", 32'(fifo_cnt), 32'(5));
        rst_n = 1'b0;
        #2;
        check("mid_rst_cnt", 32'(fifo_cnt), 32'(0));
        check("mid_rst_valid", 32'(rec_valid), 32'(0));
        wait_cyc(2);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(4);

        m = bus_mask(0);
        drv_start(m);
        drv_byte(m, 8'($urandom), 1'b1);
        drv_stop(m);
        drain_all("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
